// File: rtl/regfile_reader_if.sv
// Read-port and output-stream bundle between regfile_reader and its surroundings.
// master = the reader (drives r_addr and the stream); slave = register file plus consumer.
interface regfile_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, start_addr, count, r_data, out_ready,
    output r_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output start, start_addr, count, r_data, out_ready,
    input  r_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/regfile_reader.sv
// Streams count consecutive register-file words (address wraps) out over valid/ready.
// First word 2 cycles after start, one word per 2 cycles; word and last held while out_ready is low.
module regfile_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  regfile_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n;
  logic [ADDR_WIDTH:0]   remaining, remaining_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  valid_q, valid_n;
  logic                  last_q, last_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      remaining <= remaining_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      last_q    <= last_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    remaining_n = remaining;
    data_n      = data_q;
    valid_n     = valid_q;
    last_n      = last_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            cur_addr_n  = bus.start_addr;
            remaining_n = bus.count;
            busy_n      = 1'b1;
            state_n     = FETCH;
          end else begin
            // Empty burst still completes, so the requester sees a done.
            done_n = 1'b1;
          end
        end
      end
      FETCH: begin
        data_n  = bus.r_data;
        valid_n = 1'b1;
        last_n  = (remaining == REM_ONE);
        state_n = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          valid_n = 1'b0;
          if (last_q) begin
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            remaining_n = remaining - REM_ONE;
            cur_addr_n  = cur_addr + ADDR_ONE;
            state_n     = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.r_addr    = cur_addr;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
Sequential read-out engine that sits on the read port of a `register_file` instance. It drives that port's `r_addr`, samples `r_data`, and streams a block of words out over a valid/ready interface. It is the consumer counterpart to the register file's write path. Typical uses: dumping register contents to a serial link, or feeding a downstream datapath.

Parameters:
- DATA_WIDTH, 8, width of each register word and of out_data
- ADDR_WIDTH, 2, register address width; register file depth is 2**ADDR_WIDTH

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a read-out burst; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first register address of the burst; latched on accepted start
- count  in  ADDR_WIDTH+1  number of words to read; latched on accepted start
- r_addr  out  ADDR_WIDTH  read address to the register file (registered)
- r_data  in  DATA_WIDTH  combinational read data from the register file
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts the word when high together with out_valid
- out_data  out  DATA_WIDTH  word being presented
- out_last  out  1  high with out_valid on the final word of a burst
- busy  out  1  high from an accepted start until the burst completes
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; r_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Reset overrides all other inputs.
- Reset mid-burst: the burst is abandoned. There is no done pulse, and out_valid drops on the next cycle.
- Internal state: FSM with states IDLE, FETCH, SEND; cur_addr (ADDR_WIDTH bits); remaining (ADDR_WIDTH+1 bits).
- IDLE:
  - busy=0, out_valid=0.
  - start=1 and count!=0: latch r_addr←start_addr and remaining←count; busy←1; go to FETCH.
  - start=1 and count==0: pulse done on the next cycle; no beats; stay IDLE; busy stays 0.
- FETCH (exactly 1 cycle):
  - r_addr is stable at the current address.
  - At the end of the cycle: out_data←r_data, out_valid←1, out_last←(remaining==1); go to SEND.
- SEND:
  - out_valid=1. out_data and out_last are held stable until the handshake (out_valid & out_ready).
  - On handshake, not last: remaining←remaining-1; r_addr←r_addr+1 with modulo 2**ADDR_WIDTH wrap (max→0); out_valid←0; go to FETCH.
  - On handshake, last: out_valid←0, out_last←0, busy←0, done←1 for one cycle; go to IDLE.
- Throughput: one word per 2 cycles with out_ready tied high.
- Latency: first out_valid is 2 cycles after the cycle in which start is sampled.
- start while busy (FETCH/SEND): ignored; the latched start_addr and count are unaffected.
- count > 2**ADDR_WIDTH: legal. The address wraps and registers are re-read in order.
- done and a new start may be accepted in the same cycle, since the FSM is already IDLE when done is high.
- out_valid never drops without a handshake except under rst.

Test Plan:
1. Preload the register_file (DATA_WIDTH=8, ADDR_WIDTH=2) via its write port: R0..R3 = FF, EE, DD, CC. Then start with start_addr=0, count=4, out_ready=1.
   -> Beats FF, EE, DD, CC, each 2 cycles apart. out_last only on CC. done pulses once. busy=0 afterwards.
2. Wrap: start_addr=2, count=3.
   -> Beats DD, CC, FF. r_addr sequence 2, 3, 0. out_last on FF.
3. Backpressure: start_addr=1, count=2, out_ready=0 for 3 cycles after the first out_valid.
   -> out_data=EE and out_valid=1 held for all 3 cycles. Then beats EE, DD. done after DD.
4. Edge starts: count=0 -> done pulse the next cycle, out_valid never high. A second start (start_addr=3) pulsed during SEND of a count=2 burst from 0 -> ignored; beats are FF, EE only.
5. Reset mid-burst: assert rst while out_valid=1 on the 2nd beat of a count=4 burst.
   -> The following cycle: out_valid=0, busy=0, r_addr=0, no done pulse. A fresh start with start_addr=3, count=1 then yields a single CC beat with out_last=1.
